// File: rtl/adpcm_rom_arbiter.sv
// adpcm_rom_arbiter: round-robin share of one byte-wide sample-ROM read port among ADPCM voices, with ROM timeout
// Ports: clk_i/reset_i (sync, active-high); vreq_i/vaddr_i per-voice level request + address;
//   vack_o one-cycle per-voice ack, vdata_o shared return byte; rom_addr_o/rom_rd_o/rom_ack_i/rom_data_i memory side;
//   flush_i cache invalidate; grant_id_o last granted voice; busy_o in WAIT/DONE; timeout_err_o aborted-access pulse.
// Optional: define ADPCM_ARB_CACHE_EN for a one-entry per-voice read cache (otherwise flush_i is unused).
module adpcm_rom_arbiter #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W = 18,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_VOICES-1:0]        vreq_i,
  input  logic [NUM_VOICES*ADDR_W-1:0] vaddr_i,
  output logic [NUM_VOICES-1:0]        vack_o,
  output logic [7:0]                   vdata_o,
  output logic [ADDR_W-1:0]            rom_addr_o,
  output logic                         rom_rd_o,
  input  logic                         rom_ack_i,
  input  logic [7:0]                   rom_data_i,
  input  logic                         flush_i,
  output logic [2:0]                   grant_id_o,
  output logic                         busy_o,
  output logic                         timeout_err_o
);
  localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int JW = IW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  state_e state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [ADDR_W-1:0] rom_addr_q, addr_d;
  logic rom_rd_q, rd_d;
  logic [7:0] vdata_q, vdata_d;
  logic [NUM_VOICES-1:0] vack_q, vack_d;
  logic terr_q, terr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] va [NUM_VOICES];
  logic [IW-1:0] win, gi;
  logic [JW-1:0] j;
  logic found, hit;
  logic [7:0] hit_data;
  genvar i;
  generate
    for (i = 0; i < NUM_VOICES; i++) begin : g_va
      assign va[i] = vaddr_i[i*ADDR_W +: ADDR_W];
    end
  endgenerate
  assign gi = grant_q[IW-1:0];
  // Scan upward from the voice after the last grant; the last grant itself is checked last.
  always_comb begin
    win = gi;
    found = 1'b0;
    j = '0;
    for (int k = 1; k <= NUM_VOICES; k++) begin
      j = JW'(gi) + JW'(k);
      j = j >= JW'(NUM_VOICES) ? j - JW'(NUM_VOICES) : j;
      if (!found && vreq_i[j[IW-1:0]]) begin
        found = 1'b1;
        win = j[IW-1:0];
      end
    end
  end
`ifdef ADPCM_ARB_CACHE_EN
  logic [NUM_VOICES-1:0] cv_q;
  logic [ADDR_W-1:0] ctag_q [NUM_VOICES];
  logic [7:0] cdat_q [NUM_VOICES];
  assign hit = cv_q[win] && ctag_q[win] == va[win];
  assign hit_data = cdat_q[win];
  // Flush wins over a same-edge fill; timeout completions never fill.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) cv_q <= '0;
    else if (state_q == WAIT && rom_ack_i) cv_q[gi] <= 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (state_q == WAIT && rom_ack_i) begin
      ctag_q[gi] <= rom_addr_q;
      cdat_q[gi] <= rom_data_i;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign hit = 1'b0;
  assign hit_data = 8'h00;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d = rom_addr_q;
    rd_d = rom_rd_q;
    vdata_d = vdata_q;
    vack_d = '0;
    terr_d = 1'b0;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (found) begin
        grant_d = 3'(win);
        addr_d = va[win];
        cnt_d = '0;
        rd_d = !hit;
        vdata_d = hit ? hit_data : vdata_q;
        vack_d[win] = hit;
        state_d = hit ? DONE : WAIT;
      end
      WAIT: if (rom_ack_i) begin
        rd_d = 1'b0;
        vdata_d = rom_data_i;
        vack_d[gi] = 1'b1;
        state_d = DONE;
      end else if (cnt_q == 8'(TIMEOUT)) begin
        rd_d = 1'b0;
        vdata_d = 8'h00;
        vack_d[gi] = 1'b1;
        terr_d = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= 3'(NUM_VOICES - 1);
      rom_addr_q <= '0;
      rom_rd_q <= 1'b0;
      vdata_q <= '0;
      vack_q <= '0;
      terr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rom_addr_q <= addr_d;
      rom_rd_q <= rd_d;
      vdata_q <= vdata_d;
      vack_q <= vack_d;
      terr_q <= terr_d;
      cnt_q <= cnt_d;
    end
  end
  assign vack_o = vack_q;
  assign vdata_o = vdata_q;
  assign rom_addr_o = rom_addr_q;
  assign rom_rd_o = rom_rd_q;
  assign grant_id_o = grant_q;
  assign busy_o = state_q != IDLE;
  assign timeout_err_o = terr_q;
endmodule

// File: tb/tb_adpcm_rom_arbiter.sv
// tb_adpcm_rom_arbiter: directed self-checking bench for adpcm_rom_arbiter
module tb_adpcm_rom_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] vreq;
  logic [4*18-1:0] vaddr;
  logic [3:0] vack;
  logic [7:0] vdata;
  logic [17:0] rom_addr;
  logic rom_rd;
  logic rom_ack;
  logic [7:0] rom_data;
  logic flush;
  logic [2:0] grant_id;
  logic busy;
  logic terr;
  int total = 0;
  int passed = 0;
  logic [17:0] ea [4];
  adpcm_rom_arbiter #(.NUM_VOICES(4), .ADDR_W(18), .TIMEOUT(16)) dut (
    .clk_i(clk),
    .reset_i(reset),
    .vreq_i(vreq),
    .vaddr_i(vaddr),
    .vack_o(vack),
    .vdata_o(vdata),
    .rom_addr_o(rom_addr),
    .rom_rd_o(rom_rd),
    .rom_ack_i(rom_ack),
    .rom_data_i(rom_data),
    .flush_i(flush),
    .grant_id_o(grant_id),
    .busy_o(busy),
    .timeout_err_o(terr)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  initial begin
    reset = 1'b1;
    vreq = '0;
    vaddr = '0;
    rom_ack = 1'b0;
    rom_data = '0;
    flush = 1'b0;
    tick;
    tick;
    chk("rst_vack", 32'(vack), 0);
    chk("rst_vdata", 32'(vdata), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_rd", 32'(rom_rd), 0);
    chk("rst_grant", 32'(grant_id), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(terr), 0);
    reset = 1'b0;
    tick;
    vreq = 4'b0001;
    vaddr[0 +: 18] = 18'h00123;
    tick;
    chk("single_rd", 32'(rom_rd), 1);
    chk("single_addr", 32'(rom_addr), 32'h123);
    chk("single_grant", 32'(grant_id), 0);
    chk("single_busy", 32'(busy), 1);
    chk("single_noack", 32'(vack), 0);
    rom_ack = 1'b1;
    rom_data = 8'hA5;
    tick;
    rom_ack = 1'b0;
    chk("single_vack", 32'(vack), 4'b0001);
    chk("single_vdata", 32'(vdata), 8'hA5);
    chk("single_rd_low", 32'(rom_rd), 0);
    chk("single_busy_done", 32'(busy), 1);
    vreq = 4'b0000;
    tick;
    chk("single_vack_end", 32'(vack), 0);
    chk("single_idle", 32'(busy), 0);
    chk("single_vdata_hold", 32'(vdata), 8'hA5);
    rom_ack = 1'b1;
    rom_data = 8'h5A;
    tick;
    rom_ack = 1'b0;
    chk("late_vack", 32'(vack), 0);
    chk("late_busy", 32'(busy), 0);
    chk("late_rd", 32'(rom_rd), 0);
    tick;
    chk("late_vack2", 32'(vack), 0);
    for (int v = 0; v < 4; v++) begin
      ea[v] = 18'(32'h100 + v);
      vaddr[v*18 +: 18] = ea[v];
    end
    vreq = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      int e;
      e = (1 + n) % 4;
      tick;
      chk("rr_grant", 32'(grant_id), 32'(e));
      chk("rr_rd", 32'(rom_rd), 1);
      chk("rr_addr", 32'(rom_addr), 32'(ea[e]));
      chk("rr_noack", 32'(vack), 0);
      rom_ack = 1'b1;
      rom_data = 8'(8'h50 + e);
      tick;
      rom_ack = 1'b0;
      chk("rr_vack", 32'(vack), 32'(1 << e));
      chk("rr_vdata", 32'(vdata), 32'(8'h50 + e));
      chk("rr_rd_low", 32'(rom_rd), 0);
      vreq[e] = 1'b0;
      tick;
      chk("rr_vack_end", 32'(vack), 0);
      chk("rr_idle", 32'(busy), 0);
      vreq[e] = 1'b1;
      ea[e] = 18'(32'h200 + e);
      vaddr[e*18 +: 18] = ea[e];
    end
    vreq = 4'b0100;
    vaddr[2*18 +: 18] = 18'h2AAAA;
    tick;
    chk("to_rd", 32'(rom_rd), 1);
    chk("to_grant", 32'(grant_id), 2);
    chk("to_addr", 32'(rom_addr), 32'h2AAAA);
    for (int c = 1; c <= 16; c++) begin
      tick;
      chk("to_wait_rd", 32'(rom_rd), 1);
      chk("to_wait_vack", 32'(vack), 0);
    end
    tick;
    chk("to_vack", 32'(vack), 4'b0100);
    chk("to_err", 32'(terr), 1);
    chk("to_vdata", 32'(vdata), 0);
    chk("to_rd_low", 32'(rom_rd), 0);
    vreq = 4'b0000;
    tick;
    chk("to_vack_end", 32'(vack), 0);
    chk("to_err_end", 32'(terr), 0);
    chk("to_idle", 32'(busy), 0);
    vreq = 4'b0001;
    vaddr[0 +: 18] = 18'h00123;
    tick;
    chk("rm_rd", 32'(rom_rd), 1);
    chk("rm_grant", 32'(grant_id), 0);
    vreq = 4'b0000;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rm_rd_low", 32'(rom_rd), 0);
    chk("rm_grant_rst", 32'(grant_id), 3);
    chk("rm_busy", 32'(busy), 0);
    rom_ack = 1'b1;
    rom_data = 8'hEE;
    tick;
    rom_ack = 1'b0;
    chk("rm_noack", 32'(vack), 0);
    chk("rm_rd_still_low", 32'(rom_rd), 0);
    vreq = 4'b0001;
    tick;
    chk("rm_regrant", 32'(grant_id), 0);
    chk("rm_regrant_rd", 32'(rom_rd), 1);
    rom_ack = 1'b1;
    rom_data = 8'h3C;
    tick;
    rom_ack = 1'b0;
    chk("rm_vack", 32'(vack), 4'b0001);
    chk("rm_vdata", 32'(vdata), 8'h3C);
    vreq = 4'b0000;
    tick;
    chk("rm_vack_end", 32'(vack), 0);
`ifdef ADPCM_ARB_CACHE_EN
    vaddr[1*18 +: 18] = 18'h00400;
    vreq = 4'b0010;
    tick;
    chk("c1_rd", 32'(rom_rd), 1);
    chk("c1_grant", 32'(grant_id), 1);
    rom_ack = 1'b1;
    rom_data = 8'h77;
    tick;
    rom_ack = 1'b0;
    chk("c1_vack", 32'(vack), 4'b0010);
    chk("c1_vdata", 32'(vdata), 8'h77);
    vreq = 4'b0000;
    tick;
    vreq = 4'b0010;
    tick;
    chk("c2_hit_vack", 32'(vack), 4'b0010);
    chk("c2_hit_rd", 32'(rom_rd), 0);
    chk("c2_hit_vdata", 32'(vdata), 8'h77);
    chk("c2_busy", 32'(busy), 1);
    vreq = 4'b0000;
    tick;
    chk("c2_vack_end", 32'(vack), 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    vreq = 4'b0010;
    tick;
    chk("c3_rd", 32'(rom_rd), 1);
    chk("c3_noack", 32'(vack), 0);
    rom_ack = 1'b1;
    rom_data = 8'h78;
    tick;
    rom_ack = 1'b0;
    chk("c3_vack", 32'(vack), 4'b0010);
    chk("c3_vdata", 32'(vdata), 8'h78);
    vreq = 4'b0000;
    tick;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adpcm_rom_arbiter.md
Name: adpcm_rom_arbiter

Overview:
- Shares one sample-ROM read port between NUM_VOICES ADPCM voice engines.
- Each voice raises a byte-read request. The arbiter grants requests round-robin, drives the ROM port, waits for the memory acknowledge, and returns the data with a one-cycle ack to the winning voice.
- Sits between the voice sequencers and the SDRAM/BRAM ROM controller.
- Also guards against a stalled memory with a timeout.

Parameters:
- NUM_VOICES, 4, number of voice requesters (2..8).
- ADDR_W, 18, ROM byte-address width.
- TIMEOUT, 255, max cycles to wait for ROM_ACK before aborting (1..255).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- VREQ  in  NUM_VOICES  per-voice read request, level, held until that voice's VACK.
- VADDR  in  NUM_VOICES*ADDR_W  per-voice byte address; voice i at [i*ADDR_W +: ADDR_W]; stable while VREQ[i] high.
- VACK  out  NUM_VOICES  one-cycle pulse; VDATA valid for voice i.
- VDATA  out  8  returned byte, shared by all voices, valid while any VACK bit is high.
- ROM_ADDR  out  ADDR_W  address to memory.
- ROM_RD  out  1  memory read request, level, held until ROM_ACK.
- ROM_ACK  in  1  memory ack, single-cycle pulse, ROM_DATA valid in the same cycle.
- ROM_DATA  in  8  memory read data.
- FLUSH  in  1  invalidate cache (ROM contents changed); ignored unless the cache macro is defined.
- GRANT_ID  out  3  index of the voice currently or last granted.
- BUSY  out  1  high in WAIT and DONE.
- TIMEOUT_ERR  out  1  one-cycle pulse when a ROM access is aborted by the timeout.

Behaviour:
- Reset values: VACK=0, VDATA=0, ROM_ADDR=0, ROM_RD=0, GRANT_ID=NUM_VOICES-1 (so voice 0 wins first), BUSY=0, TIMEOUT_ERR=0, state=IDLE, timeout counter=0.
- Reset mid-access: ROM_RD drops on the next edge, and no VACK is issued for the access.

State machine:
- IDLE:
  - If no VREQ bit is set, stay in IDLE.
  - Otherwise pick the winner g = first set VREQ bit scanning from GRANT_ID+1 upward, wrapping at NUM_VOICES.
  - Set GRANT_ID<=g, ROM_ADDR<=VADDR[g], ROM_RD<=1, counter<=0, and go to WAIT.
- WAIT:
  - If ROM_ACK=1:
    - ROM_RD<=0, VDATA<=ROM_DATA, VACK[g]<=1, go to DONE.
  - Else if counter==TIMEOUT:
    - ROM_RD<=0, VDATA<=8'h00, VACK[g]<=1, TIMEOUT_ERR<=1, go to DONE.
  - Else counter++.
- DONE:
  - VACK and TIMEOUT_ERR return to 0, go to IDLE.
  - The requester drops VREQ in this cycle. The arbiter does not sample VREQ in DONE, so a stale request is never re-granted.

Timing and rules:
- Latency: VREQ sampled high at edge 0, ROM_RD high after edge 0. If ROM_ACK is high in that first cycle, VACK is high after edge 1. Minimum 2 cycles from grant to VACK; one access per 3 cycles sustained.
- Only one VACK bit is ever high at a time, and VACK is never high while ROM_RD is high.
- ROM_ACK outside WAIT is ignored.
- A VREQ deasserted before its VACK is a requester protocol error. The arbiter still completes the access and pulses VACK.
- Fairness: with all voices requesting continuously, the grant order is 0,1,2,3,0,… and no voice waits more than NUM_VOICES-1 accesses.
- Timeout counter is 8 bits and never wraps, because it is compared before incrementing.

Optional Feature:
- Macro: ADPCM_ARB_CACHE_EN.
- When defined:
  - Each voice has a one-entry cache of {valid, tag[ADDR_W], data[8]}.
  - In IDLE, if the winner's VADDR equals its valid tag, go directly to DONE with VDATA<=cached data and VACK pulsed. ROM_RD stays low, giving a 1-cycle grant-to-VACK latency.
  - The cache entry is filled on each ROM_ACK completion.
  - Timeout completions do not fill the cache.
  - RESET or FLUSH=1 clears all valid bits on that edge. FLUSH takes priority over a same-cycle fill.
  - This serves the second nibble of each ADPCM byte without a ROM access.
- When not defined: no cache storage exists, FLUSH is unused, and every request performs a ROM access.

Test Plan:
- Single request: VREQ=4'b0001, VADDR[0]=18'h00123, memory acks 1 cycle after ROM_RD with 8'hA5 -> ROM_ADDR=18'h00123, VACK=4'b0001 for exactly one cycle, VDATA=8'hA5, ROM_RD low afterwards.
- Round-robin: VREQ=4'b1111 held, each voice deasserting after its ack and re-asserting one cycle later -> grant order 0,1,2,3,0,1; GRANT_ID follows; no VACK overlap.
- Timeout: TIMEOUT=16, ROM_ACK never asserted, VREQ=4'b0100 -> VACK[2] and TIMEOUT_ERR pulse 17 cycles after ROM_RD rises, VDATA=8'h00, ROM_RD=0.
- Reset mid-access: assert RESET while in WAIT, then pulse ROM_ACK after reset releases -> no VACK, ROM_RD=0, GRANT_ID=3, next VREQ=4'b0001 is granted normally.
- Cache (ADPCM_ARB_CACHE_EN): voice 1 reads 18'h00400 twice -> first read uses ROM, second read gives VACK 1 cycle after grant with no ROM_RD. After FLUSH=1, a third read uses ROM again.
- Late ack: ROM_ACK pulsed while in IDLE with no request pending -> ignored, VACK stays 0, state stays IDLE.
